// File: rtl/rv_mem_pkg.sv
// Shared memory-access encodings for the miniRV decoder and load/store unit.
package rv_mem_pkg;

  // Store width select (ram_wdin_op); 3 is handled as SW.
  localparam logic [1:0] WRAM_SB = 2'd0;
  localparam logic [1:0] WRAM_SH = 2'd1;
  localparam logic [1:0] WRAM_SW = 2'd2;

  // Load width/extension select (ram_rb_op); 5-7 are handled as LW.
  localparam logic [2:0] RDO_LB  = 3'd0;
  localparam logic [2:0] RDO_LBU = 3'd1;
  localparam logic [2:0] RDO_LH  = 3'd2;
  localparam logic [2:0] RDO_LHU = 3'd3;
  localparam logic [2:0] RDO_LW  = 3'd4;

  // Load/store unit sequencing.
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting for the LSU: strobes, store-data placement,
// load extraction/extension and alignment checking. Purely combinational.
module lsu_lane_fmt
  import rv_mem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  wdin_op,
  input  logic [2:0]  rb_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [3:0]  strb_raw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store strobes and lane replication; strobes are forced to 0 for reads.
  always_comb begin
    strb_raw   = 4'hF;
    wdata_lane = wdata;
    case (wdin_op)
      WRAM_SB: begin
        strb_raw   = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      WRAM_SH: begin
        strb_raw   = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        strb_raw   = 4'hF;
        wdata_lane = wdata;
      end
    endcase
    strb = we ? strb_raw : 4'h0;
  end

  // Alignment check against the natural size of the access.
  always_comb begin
    misaligned = 1'b0;
    if (we) begin
      case (wdin_op)
        WRAM_SB: misaligned = 1'b0;
        WRAM_SH: misaligned = addr_lo[0];
        default: misaligned = |addr_lo;
      endcase
    end else begin
      case (rb_op)
        RDO_LB, RDO_LBU: misaligned = 1'b0;
        RDO_LH, RDO_LHU: misaligned = addr_lo[0];
        default:         misaligned = |addr_lo;
      endcase
    end
  end

  // Select the addressed byte/half from the response word and extend it.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (rb_op)
      RDO_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      RDO_LBU: rdata_ext = {24'h0, byte_sel};
      RDO_LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      RDO_LHU: rdata_ext = {16'h0, half_sel};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// miniRV load/store unit: converts one load/store into a single word-aligned
// bus handshake, stalls the core until done, flags misalignment and timeout.
module lsu_bus_bridge
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        mem_req,
  input  logic        ram_we,
  input  logic [1:0]  ram_wdin_op,
  input  logic [2:0]  ram_rb_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_err,
  output logic        lsu_stall,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_e       state;
  logic             we_q;
  logic [1:0]       wdin_q;
  logic [2:0]       rb_q;
  logic [1:0]       addr_lo_q;
  logic [CNT_W-1:0] cnt;

  logic             sel_we;
  logic [1:0]       sel_wdin;
  logic [2:0]       sel_rb;
  logic [1:0]       sel_addr_lo;
  logic [3:0]       fmt_strb;
  logic [31:0]      fmt_wdata;
  logic [31:0]      fmt_rdata;
  logic             fmt_misaligned;
  logic             timeout_hit;

  // The formatter sees live inputs while accepting and the latched op afterwards.
  always_comb begin
    if (state == LSU_IDLE) begin
      sel_we      = ram_we;
      sel_wdin    = ram_wdin_op;
      sel_rb      = ram_rb_op;
      sel_addr_lo = mem_addr[1:0];
    end else begin
      sel_we      = we_q;
      sel_wdin    = wdin_q;
      sel_rb      = rb_q;
      sel_addr_lo = addr_lo_q;
    end
  end

  lsu_lane_fmt u_lane_fmt (
    .we         (sel_we),
    .wdin_op    (sel_wdin),
    .rb_op      (sel_rb),
    .addr_lo    (sel_addr_lo),
    .wdata      (mem_wdata),
    .rdata      (bus_rdata),
    .strb       (fmt_strb),
    .wdata_lane (fmt_wdata),
    .rdata_ext  (fmt_rdata),
    .misaligned (fmt_misaligned)
  );

  // Counter value in the last allowed wait cycle; the following edge times out.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Stall is combinational so the core is held from the very first request cycle.
  assign lsu_stall = ((state == LSU_IDLE) && mem_req) ||
                     (state == LSU_REQ) || (state == LSU_RESP);

  // Access sequencer with registered bus and completion outputs.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state     <= LSU_IDLE;
      we_q      <= 1'b0;
      wdin_q    <= '0;
      rb_q      <= '0;
      addr_lo_q <= '0;
      cnt       <= '0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (mem_req) begin
            we_q      <= ram_we;
            wdin_q    <= ram_wdin_op;
            rb_q      <= ram_rb_op;
            addr_lo_q <= mem_addr[1:0];
            bus_we    <= ram_we;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_wstrb <= fmt_strb;
            bus_wdata <= fmt_wdata;
            cnt       <= '0;
            mem_rdata <= '0;
            if (fmt_misaligned) begin
              state    <= LSU_DONE;
              mem_done <= 1'b1;
              mem_err  <= 1'b1;
            end else begin
              state     <= LSU_REQ;
              bus_valid <= 1'b1;
            end
          end
        end
        LSU_REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (we_q) begin
              state    <= LSU_DONE;
              mem_done <= 1'b1;
              mem_err  <= 1'b0;
            end else begin
              state <= LSU_RESP;
            end
          end else if (timeout_hit) begin
            bus_valid <= 1'b0;
            state     <= LSU_DONE;
            mem_done  <= 1'b1;
            mem_err   <= 1'b1;
            mem_rdata <= '0;
          end
        end
        LSU_RESP: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid) begin
            state     <= LSU_DONE;
            mem_done  <= 1'b1;
            mem_err   <= 1'b0;
            mem_rdata <= fmt_rdata;
          end else if (timeout_hit) begin
            state     <= LSU_DONE;
            mem_done  <= 1'b1;
            mem_err   <= 1'b1;
            mem_rdata <= '0;
          end
        end
        default: begin
          state    <= LSU_IDLE;
          mem_done <= 1'b0;
          mem_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge with a short bus timeout.
module tb_lsu_bus_bridge;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        mem_req;
  logic        ram_we;
  logic [1:0]  ram_wdin_op;
  logic [2:0]  ram_rb_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;
  logic        lsu_stall;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int hs_cnt;
  int done_cnt;

  always #5 cpu_clk = ~cpu_clk;

  lsu_bus_bridge #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .mem_req     (mem_req),
    .ram_we      (ram_we),
    .ram_wdin_op (ram_wdin_op),
    .ram_rb_op   (ram_rb_op),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .mem_err     (mem_err),
    .lsu_stall   (lsu_stall),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Aligned load: REQ, handshake, RESP, rvalid, DONE. A stray rvalid in REQ must be ignored.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp);
    mem_req = 1'b1; ram_we = 1'b0; ram_rb_op = op; mem_addr = addr;
    bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    chk({tag, "_req_valid"}, {31'd0, bus_valid}, 32'd1);
    chk({tag, "_req_strb"}, {28'd0, bus_wstrb}, 32'd0);
    chk({tag, "_req_addr"}, bus_addr, {addr[31:2], 2'b00});
    bus_rvalid = 1'b0;
    step();
    chk({tag, "_resp_done"}, {31'd0, mem_done}, 32'd0);
    chk({tag, "_resp_stall"}, {31'd0, lsu_stall}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, bus_valid}, 32'd0);
    bus_rvalid = 1'b1; bus_rdata = word;
    step();
    chk({tag, "_done"}, {31'd0, mem_done}, 32'd1);
    chk({tag, "_err"}, {31'd0, mem_err}, 32'd0);
    chk({tag, "_rdata"}, mem_rdata, exp);
    bus_rvalid = 1'b0; mem_req = 1'b0;
    step();
    chk({tag, "_idle_done"}, {31'd0, mem_done}, 32'd0);
  endtask

  initial begin
    cpu_rst = 1'b1; mem_req = 1'b0; ram_we = 1'b0; ram_wdin_op = 2'd0; ram_rb_op = 3'd0;
    mem_addr = '0; mem_wdata = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    step();
    step();
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_stall", {31'd0, lsu_stall}, 32'd0);
    cpu_rst = 1'b0;
    step();

    // SB at 0x1003: byte replicated on all lanes, top strobe only.
    mem_req = 1'b1; ram_we = 1'b1; ram_wdin_op = 2'd0; mem_addr = 32'h0000_1003;
    mem_wdata = 32'h0000_00A5; bus_ready = 1'b1;
    #1;
    chk("sb_c0_stall", {31'd0, lsu_stall}, 32'd1);
    step();
    chk("sb_c1_valid", {31'd0, bus_valid}, 32'd1);
    chk("sb_c1_we", {31'd0, bus_we}, 32'd1);
    chk("sb_c1_addr", bus_addr, 32'h0000_1000);
    chk("sb_c1_strb", {28'd0, bus_wstrb}, 32'h8);
    chk("sb_c1_wdata", bus_wdata, 32'hA5A5_A5A5);
    chk("sb_c1_done", {31'd0, mem_done}, 32'd0);
    step();
    chk("sb_c2_done", {31'd0, mem_done}, 32'd1);
    chk("sb_c2_err", {31'd0, mem_err}, 32'd0);
    chk("sb_c2_valid", {31'd0, bus_valid}, 32'd0);
    chk("sb_c2_stall", {31'd0, lsu_stall}, 32'd0);
    mem_req = 1'b0;
    step();
    chk("sb_c3_done", {31'd0, mem_done}, 32'd0);

    // SH at 0x7002: upper half strobes, half replicated.
    mem_req = 1'b1; ram_we = 1'b1; ram_wdin_op = 2'd1; mem_addr = 32'h0000_7002;
    mem_wdata = 32'hFFFF_BEEF;
    step();
    chk("sh_strb", {28'd0, bus_wstrb}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    step();
    chk("sh_done", {31'd0, mem_done}, 32'd1);
    mem_req = 1'b0;
    step();

    do_load("lh", 3'd2, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lhu", 3'd3, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001);
    do_load("lb", 3'd0, 32'h0000_2001, 32'h8001_1234, 32'h0000_0012);
    do_load("lb_neg", 3'd0, 32'h0000_2003, 32'h8001_1234, 32'hFFFF_FF80);
    do_load("lw", 3'd4, 32'h0000_2004, 32'h8001_1234, 32'h8001_1234);

    // Misaligned SW: completes with error and no bus request.
    mem_req = 1'b1; ram_we = 1'b1; ram_wdin_op = 2'd2; mem_addr = 32'h0000_3002;
    step();
    chk("sw_mis_done", {31'd0, mem_done}, 32'd1);
    chk("sw_mis_err", {31'd0, mem_err}, 32'd1);
    chk("sw_mis_valid", {31'd0, bus_valid}, 32'd0);
    mem_req = 1'b0;
    step();
    chk("sw_mis_valid2", {31'd0, bus_valid}, 32'd0);
    chk("sw_mis_done2", {31'd0, mem_done}, 32'd0);

    // Misaligned LH at odd address.
    mem_req = 1'b1; ram_we = 1'b0; ram_rb_op = 3'd2; mem_addr = 32'h0000_2001;
    step();
    chk("lh_mis_err", {31'd0, mem_err}, 32'd1);
    chk("lh_mis_valid", {31'd0, bus_valid}, 32'd0);
    mem_req = 1'b0;
    step();

    // LW timeout: four request cycles, then error completion with zero data.
    mem_req = 1'b1; ram_we = 1'b0; ram_rb_op = 3'd4; mem_addr = 32'h0000_4000; bus_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("to_valid_c%0d", i), {31'd0, bus_valid}, 32'd1);
      chk($sformatf("to_done_c%0d", i), {31'd0, mem_done}, 32'd0);
    end
    step();
    chk("to_done", {31'd0, mem_done}, 32'd1);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_rdata", mem_rdata, 32'd0);
    chk("to_valid_off", {31'd0, bus_valid}, 32'd0);
    mem_req = 1'b0;
    step();
    chk("to_idle_done", {31'd0, mem_done}, 32'd0);
    chk("to_idle_stall", {31'd0, lsu_stall}, 32'd0);

    // Reset while waiting in RESP; a late rvalid must not complete anything.
    mem_req = 1'b1; ram_we = 1'b0; ram_rb_op = 3'd4; mem_addr = 32'h0000_5004; bus_ready = 1'b1;
    mem_wdata = 32'h1234_5678;
    step();
    step();
    chk("rst_resp_stall", {31'd0, lsu_stall}, 32'd1);
    cpu_rst = 1'b1; mem_req = 1'b0;
    step();
    cpu_rst = 1'b0;
    chk("rst_mid_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_mid_addr", bus_addr, 32'd0);
    chk("rst_mid_done", {31'd0, mem_done}, 32'd0);
    chk("rst_mid_stall", {31'd0, lsu_stall}, 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_late_done%0d", i), {31'd0, mem_done}, 32'd0);
    end
    bus_rvalid = 1'b0;

    // Back-to-back SW then LW with mem_req held high across DONE.
    hs_cnt = 0; done_cnt = 0;
    mem_req = 1'b1; ram_we = 1'b1; ram_wdin_op = 2'd2; mem_addr = 32'h0000_6000;
    mem_wdata = 32'h1122_3344; bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus_valid && bus_ready) begin
        hs_cnt++;
        if (hs_cnt == 1) chk("b2b_sw_wdata", bus_wdata, 32'h1122_3344);
      end
      if (mem_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          ram_we = 1'b0; ram_rb_op = 3'd4; mem_addr = 32'h0000_6004;
        end else begin
          chk("b2b_lw_rdata", mem_rdata, 32'hCAFE_F00D);
          mem_req = 1'b0;
        end
      end
    end
    bus_rvalid = 1'b0;
    chk("b2b_handshakes", hs_cnt, 32'd2);
    chk("b2b_dones", done_cnt, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
# lsu_bus_bridge

Load/store unit for the multi-cycle and pipelined miniRV cores: the consumer of the decoder's `ram_we`, `ram_wdin_op` and `ram_rb_op` controls. It turns one load or store into a single word-aligned handshake on the data bus and generates byte strobes, store-data lane placement and load extraction/extension. It stalls the core until the access completes, and flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT_CYC`, default 255: bus wait limit in cycles, counted from the first `bus_valid` cycle; must be ≤ 2^`CNT_W`−1.
- `CNT_W`, default 8: timeout counter width.
- `cpu_clk` in, 1: the only clock; all state changes on its rising edge.
- `cpu_rst` in, 1: synchronous, active-high reset.
- `mem_req` in, 1: current instruction is a load or store; held by the core until `mem_done`.
- `ram_we` in, 1: 1 = store, 0 = load.
- `ram_wdin_op` in, 2: 0 SB, 1 SH, 2 SW; 3 is treated as SW.
- `ram_rb_op` in, 3: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; 5–7 are treated as LW.
- `mem_addr` in, 32: byte address from the ALU.
- `mem_wdata` in, 32: rs2 value, with the datum in the low bits.
- `mem_rdata` out, 32: extended load result; valid only while `mem_done`=1.
- `mem_done` out, 1: one-cycle completion pulse.
- `mem_err` out, 1: qualifies `mem_done`; 1 = misaligned access or timeout.
- `lsu_stall` out, 1: freezes PC and pipeline registers.
- `bus_valid` out, 1: request valid.
- `bus_ready` in, 1: request accepted when `bus_valid` & `bus_ready` are both 1.
- `bus_we` out, 1: write request.
- `bus_addr` out, 32: `{mem_addr[31:2],2'b00}`.
- `bus_wstrb` out, 4: byte enables; 0 for reads.
- `bus_wdata` out, 32: lane-placed store data.
- `bus_rvalid` in, 1: read response valid.
- `bus_rdata` in, 32: read response word.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: on `mem_req`=1, latch `ram_we`, op, address and lane-placed data, then check alignment.
  - Misaligned (SH/LH/LHU with `addr[0]`=1, or SW/LW with `addr[1:0]`≠0): go to DONE with err=1. No bus access is made.
  - Aligned: go to REQ.
- REQ: `bus_valid`=1.
  - On handshake with a store: go to DONE.
  - On handshake with a load: go to RESP.
- RESP: on `bus_rvalid`, register the extracted load value and go to DONE.
- DONE: `mem_done`=1 for one cycle, then go to IDLE. `mem_req` is ignored in DONE.
- Timeout counter:
  - Cleared on IDLE→REQ; increments every cycle in REQ or RESP.
  - When it reaches `TIMEOUT_CYC` without completion, go to DONE with err=1 and rdata=0. `bus_valid` drops.
  - A handshake or `bus_rvalid` in the same cycle as the limit wins: normal completion.
- Store lanes:
  - SB: strb = `1<<addr[1:0]`; the byte is replicated on all four lanes.
  - SH: strb = `4'b0011<<addr[1:0]`; the half is replicated on both halves.
  - SW: strb = 4'hF; data passed through.
- Load extraction:
  - The byte or half is selected by `addr[1:0]` from `bus_rdata`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- `lsu_stall` = (IDLE & `mem_req`) | REQ | RESP. It is 0 in DONE, so the core advances on the `mem_done` edge.
- Bus outputs are registered. `bus_addr`, `bus_we`, `bus_wstrb` and `bus_wdata` are stable throughout REQ.

## Timing
- Reset: state = IDLE. All of these are 0: `bus_valid`, `bus_we`, `bus_wstrb`, `bus_addr`, `bus_wdata`, `mem_done`, `mem_err`, `mem_rdata`, counter. `lsu_stall` follows its equation (it equals `mem_req`).
- Reset mid-access returns to IDLE on that edge. `bus_valid` drops with no completion; the bus resets with the core.
- Store latency with zero-wait ready:
  - cycle 0: IDLE sees `mem_req`;
  - cycle 1: REQ, handshake;
  - cycle 2: DONE.
  - Total: stall for 2 cycles, `mem_done` in cycle 2.
- Load with `bus_rvalid` one cycle after the handshake: REQ in cycle 1, RESP in cycle 2, DONE in cycle 3.
- Misaligned access: DONE in cycle 1, with `bus_valid` never asserted.
- `bus_rvalid` outside RESP is ignored.

## Structure
- Shared package `rv_mem_pkg` holds:
  - `WRAM_SB`/`WRAM_SH`/`WRAM_SW`;
  - `RDO_LB`/`RDO_LBU`/`RDO_LH`/`RDO_LHU`/`RDO_LW`;
  - the LSU state encodings.
- The decoder uses the same package.
- Sub-module `lsu_lane_fmt` is combinational and holds strobe generation, store-data placement, load extraction/extension and the misalignment check. The FSM and counter stay in the top.

## Test plan
- SB, addr 0x1003, wdata 0x0000_00A5, ready=1 → `bus_addr` 0x1000, strb 4'b1000, wdata 0xA5A5_A5A5; `mem_done` in cycle 2, err=0.
- LH, addr 0x2002, `bus_rdata` 0x8001_1234, rvalid one cycle after accept → `mem_rdata` 0xFFFF_8001. LHU at the same address → 0x0000_8001. LB at 0x2001 → 0x0000_0012.
- SW, addr 0x3002 → `mem_done`=1 and `mem_err`=1 in cycle 1; `bus_valid` never 1.
- LW with `bus_ready` held 0 and `TIMEOUT_CYC`=4 → `bus_valid` for 4 cycles, then `mem_done`/`mem_err`=1, `mem_rdata`=0, IDLE next.
- `cpu_rst`=1 in RESP → next cycle IDLE with all outputs 0. A `bus_rvalid` arriving later produces no `mem_done`.
- Back-to-back: SW then LW with `mem_req` held high across DONE → exactly two `bus_valid` handshakes and two `mem_done` pulses, with no duplicate access.
